// File: rtl/flash_arb_if.sv
// Wishbone-classic read channel (cyc/adr out of the master, ack/rdt back).
// One instance per requester and one toward the SPI flash controller.
interface flash_arb_if;
  logic        cyc;
  logic [31:0] adr;
  logic        ack;
  logic [31:0] rdt;

  modport master (output cyc, output adr, input ack, input rdt);
  modport slave (input cyc, input adr, output ack, output rdt);
endinterface

// File: rtl/flash_arb.sv
// Two-requester arbiter for the SPI flash controller: A has fixed priority, B is bounded-starvation.
// Optional macro FLASH_ARB_TIMEOUT_EN adds a grant watchdog that fakes an ack and flags timeout_err.
module flash_arb #(
  parameter int MAX_A   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic         wb_clk,
  input  logic         wb_rst,
  flash_arb_if.slave   a_bus,
  flash_arb_if.slave   b_bus,
  flash_arb_if.master  x_bus,
  output logic         busy,
  output logic         grant_b,
  output logic         timeout_err
);

  if (MAX_A < 1 || MAX_A > 15 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
    $error("flash_arb: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, REL} state_t;

  localparam logic [3:0] MAX_A_V = 4'(MAX_A);

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        busy_q, busy_d;
  logic        grant_b_q, grant_b_d;

  logic        in_grant;
  logic        own_a;
  logic        own_b;
  logic        owner_cyc;
  logic [31:0] owner_adr;
  logic        owner_ack;
  logic [31:0] owner_rdt;
  logic        wd_hit;

  assign own_a     = (state_q == GNT_A);
  assign own_b     = (state_q == GNT_B);
  assign in_grant  = own_a | own_b;
  assign owner_cyc = own_a ? a_bus.cyc : (own_b ? b_bus.cyc : 1'b0);
  assign owner_adr = own_a ? a_bus.adr : b_bus.adr;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIM = 16'(TIMEOUT - 1);

  logic [15:0] wdog_q, wdog_d;
  logic        timeout_err_q, timeout_err_d;

  // Counter is held at zero outside a grant, so grant cycle k sees k-1.
  assign wd_hit = in_grant & owner_cyc & ~x_bus.ack & (wdog_q == WD_LIM);

  always_comb begin
    wdog_d        = in_grant ? wdog_q + 16'd1 : 16'd0;
    timeout_err_d = timeout_err_q | wd_hit;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wdog_q        <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // x_cyc follows the owner's cyc so an abort drops the request in the same cycle.
  assign x_bus.cyc = in_grant & owner_cyc & ~wd_hit;
  assign x_bus.adr = in_grant ? owner_adr : 32'd0;

  assign owner_ack = x_bus.ack | wd_hit;
  assign owner_rdt = wd_hit ? 32'd0 : x_bus.rdt;

  // Non-owner returns zeros since the results are ORed downstream.
  assign a_bus.ack = own_a & owner_ack;
  assign a_bus.rdt = own_a ? owner_rdt : 32'd0;
  assign b_bus.ack = own_b & owner_ack;
  assign b_bus.rdt = own_b ? owner_rdt : 32'd0;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (!b_bus.cyc) begin
          starve_d = 4'd0;
        end
        if (b_bus.cyc && (!a_bus.cyc || starve_q == MAX_A_V)) begin
          state_d  = GNT_B;
          starve_d = 4'd0;
        end else if (a_bus.cyc) begin
          state_d = GNT_A;
          if (b_bus.cyc && starve_q != MAX_A_V) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      GNT_A, GNT_B: begin
        if (!owner_cyc || x_bus.ack || wd_hit) begin
          state_d = REL;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    grant_b_d = (state_d == GNT_B);
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q   <= IDLE;
      starve_q  <= 4'd0;
      busy_q    <= 1'b0;
      grant_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      busy_q    <= busy_d;
      grant_b_q <= grant_b_d;
    end
  end

  assign busy    = busy_q;
  assign grant_b = grant_b_q;

endmodule

// File: tb/tb_flash_arb.sv
// Self-checking bench for flash_arb: directed vector table, starvation and watchdog sequences,
// then random masters/slave checked against a transaction-level reference model.
module tb_flash_arb;

  localparam int MAX_A   = 4;
  localparam int TIMEOUT = 16;

  localparam logic [31:0] ADR_A = 32'h0010_0000;
  localparam logic [31:0] ADR_B = 32'h0020_0040;
  localparam logic [31:0] DAT   = 32'h1234_5678;
  localparam logic [31:0] NOISE = 32'hDEAD_BEEF;
  localparam logic [31:0] ZERO  = 32'h0000_0000;

  logic wb_clk;
  logic wb_rst;
  logic busy;
  logic grant_b;
  logic timeout_err;

  flash_arb_if a_if ();
  flash_arb_if b_if ();
  flash_arb_if x_if ();

  flash_arb #(.MAX_A(MAX_A), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .a_bus       (a_if),
    .b_bus       (b_if),
    .x_bus       (x_if),
    .busy        (busy),
    .grant_b     (grant_b),
    .timeout_err (timeout_err)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic ac, input logic [31:0] aadr,
                       input logic bc, input logic [31:0] badr,
                       input logic xack, input logic [31:0] xrdt);
    wb_rst    = rst;
    a_if.cyc  = ac;
    a_if.adr  = aadr;
    b_if.cyc  = bc;
    b_if.adr  = badr;
    x_if.ack  = xack;
    x_if.rdt  = xrdt;
  endtask

  typedef struct {
    logic        rst, ac, bc, xack;
    logic [31:0] xrdt;
    logic        e_xcyc;
    logic [31:0] e_xadr;
    logic        e_aack;
    logic [31:0] e_ardt;
    logic        e_back;
    logic [31:0] e_brdt;
    logic        e_busy, e_gb;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ac, input logic bc, input logic xack,
                              input logic [31:0] xrdt, input logic xcyc, input logic [31:0] xadr,
                              input logic aack, input logic [31:0] ardt, input logic back,
                              input logic [31:0] brdt, input logic bsy, input logic gb);
    vec_t v;
    v.rst = rst; v.ac = ac; v.bc = bc; v.xack = xack; v.xrdt = xrdt;
    v.e_xcyc = xcyc; v.e_xadr = xadr; v.e_aack = aack; v.e_ardt = ardt;
    v.e_back = back; v.e_brdt = brdt; v.e_busy = bsy; v.e_gb = gb;
    return v;
  endfunction

  // Reference model: owner 0 = none, 1 = A, 2 = B; rel marks the dead cycle after a grant.
  int m_owner;
  bit m_rel;
  int m_starve;
  int m_wd;
  bit m_terr;

  function automatic bit m_owner_cyc();
    if (m_owner == 1) return a_if.cyc;
    if (m_owner == 2) return b_if.cyc;
    return 1'b0;
  endfunction

  function automatic bit m_wd_hit();
`ifdef FLASH_ARB_TIMEOUT_EN
    return (m_owner != 0) && m_owner_cyc() && !x_if.ack && (m_wd == TIMEOUT - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    bit hit;
    hit = m_wd_hit();
    if (wb_rst) begin
      m_owner = 0; m_rel = 0; m_starve = 0; m_wd = 0; m_terr = 0;
    end else if (m_rel) begin
      m_rel = 0;
    end else if (m_owner == 0) begin
      if (!b_if.cyc) m_starve = 0;
      if (b_if.cyc && (!a_if.cyc || m_starve == MAX_A)) begin
        m_owner = 2; m_starve = 0; m_wd = 0;
      end else if (a_if.cyc) begin
        m_owner = 1; m_wd = 0;
        if (b_if.cyc) m_starve = (m_starve + 1 > MAX_A) ? MAX_A : m_starve + 1;
      end
    end else begin
      if (!m_owner_cyc() || x_if.ack || hit) begin
        m_owner = 0; m_rel = 1;
        if (hit) m_terr = 1;
      end else begin
        m_wd++;
      end
    end
  endtask

  vec_t vt[$];

  initial begin
    bit          hit, oack;
    logic [31:0] ordt;
    bit          e_aack, e_back;
    int          grants[$];
    int          gc;
    bit          done;
    bit          a_saw_ack, b_saw_ack;
    logic [31:0] exp_grant;

    n_cmp = 0;
    n_bad = 0;
    drive(1'b1, 1'b0, ZERO, 1'b0, ZERO, 1'b0, ZERO);
    repeat (2) @(posedge wb_clk);

    // Directed table: A-only read, simultaneous request, B abort, reset mid-grant.
    vt.push_back(mk(0,0,0,0,NOISE, 0,ZERO, 0,ZERO, 0,ZERO, 0,0));
    vt.push_back(mk(0,1,0,0,NOISE, 0,ZERO, 0,ZERO, 0,ZERO, 0,0));
    for (int k = 0; k < 5; k++) vt.push_back(mk(0,1,0,0,NOISE, 1,ADR_A, 0,NOISE, 0,ZERO, 1,0));
    vt.push_back(mk(0,1,0,1,DAT,   1,ADR_A, 1,DAT,   0,ZERO, 1,0));
    vt.push_back(mk(0,0,0,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 1,0));
    vt.push_back(mk(0,0,0,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 0,0));
    vt.push_back(mk(0,1,1,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 0,0));
    vt.push_back(mk(0,1,1,0,NOISE, 1,ADR_A, 0,NOISE, 0,ZERO, 1,0));
    vt.push_back(mk(0,1,1,1,DAT,   1,ADR_A, 1,DAT,   0,ZERO, 1,0));
    vt.push_back(mk(0,0,1,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 1,0));
    vt.push_back(mk(0,0,1,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 0,0));
    vt.push_back(mk(0,0,1,0,NOISE, 1,ADR_B, 0,ZERO,  0,NOISE, 1,1));
    vt.push_back(mk(0,0,1,0,NOISE, 1,ADR_B, 0,ZERO,  0,NOISE, 1,1));
    vt.push_back(mk(0,0,0,0,NOISE, 0,ADR_B, 0,ZERO,  0,NOISE, 1,1));
    vt.push_back(mk(0,0,0,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 1,0));
    vt.push_back(mk(0,0,0,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 0,0));
    vt.push_back(mk(0,1,1,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 0,0));
    vt.push_back(mk(0,1,1,0,NOISE, 1,ADR_A, 0,NOISE, 0,ZERO, 1,0));
    vt.push_back(mk(1,1,1,0,NOISE, 1,ADR_A, 0,NOISE, 0,ZERO, 1,0));
    vt.push_back(mk(0,1,0,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 0,0));
    vt.push_back(mk(0,1,0,0,NOISE, 1,ADR_A, 0,NOISE, 0,ZERO, 1,0));
    vt.push_back(mk(0,1,0,1,DAT,   1,ADR_A, 1,DAT,   0,ZERO, 1,0));
    vt.push_back(mk(0,0,0,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 1,0));
    vt.push_back(mk(0,0,0,0,NOISE, 0,ZERO,  0,ZERO,  0,ZERO, 0,0));

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge wb_clk);
      #1;
      drive(vt[i].rst, vt[i].ac, ADR_A, vt[i].bc, ADR_B, vt[i].xack, vt[i].xrdt);
      @(negedge wb_clk);
      chk($sformatf("v%0d x_cyc", i),   32'(x_if.cyc),   32'(vt[i].e_xcyc));
      chk($sformatf("v%0d x_adr", i),   x_if.adr,        vt[i].e_xadr);
      chk($sformatf("v%0d a_ack", i),   32'(a_if.ack),   32'(vt[i].e_aack));
      chk($sformatf("v%0d a_rdt", i),   a_if.rdt,        vt[i].e_ardt);
      chk($sformatf("v%0d b_ack", i),   32'(b_if.ack),   32'(vt[i].e_back));
      chk($sformatf("v%0d b_rdt", i),   b_if.rdt,        vt[i].e_brdt);
      chk($sformatf("v%0d busy", i),    32'(busy),       32'(vt[i].e_busy));
      chk($sformatf("v%0d grant_b", i), 32'(grant_b),    32'(vt[i].e_gb));
      chk($sformatf("v%0d t_err", i),   32'(timeout_err), 32'd0);
      if (vt[i].rst) begin
        @(posedge wb_clk);
        #1;
        chk("reset starve", 32'(dut.starve_q), 32'd0);
        i++;
        drive(vt[i].rst, vt[i].ac, ADR_A, vt[i].bc, ADR_B, vt[i].xack, vt[i].xrdt);
        @(negedge wb_clk);
        chk("reset x_cyc", 32'(x_if.cyc), 32'(vt[i].e_xcyc));
        chk("reset busy",  32'(busy),     32'(vt[i].e_busy));
      end
      $display("vec %0d: x_cyc=%0b x_adr=%h a_ack=%0b b_ack=%0b busy=%0b grant_b=%0b",
               i, x_if.cyc, x_if.adr, a_if.ack, b_if.ack, busy, grant_b);
    end

    // Starvation: both request forever, slave acks at once; expect A,A,A,A,B,A.
    @(posedge wb_clk); #1;
    drive(1'b1, 1'b0, ADR_A, 1'b0, ADR_B, 1'b0, ZERO);
    @(posedge wb_clk); #1;
    drive(1'b0, 1'b1, ADR_A, 1'b1, ADR_B, 1'b1, DAT);
    for (int k = 0; k < 60 && grants.size() < 6; k++) begin
      @(negedge wb_clk);
      if (x_if.cyc) grants.push_back(int'(grant_b));
    end
    chk("starve grant count", 32'(grants.size()), 32'd6);
    for (int k = 0; k < grants.size(); k++) begin
      exp_grant = (k == MAX_A) ? 32'd1 : 32'd0;
      chk($sformatf("starve grant %0d is B", k), 32'(grants[k]), exp_grant);
      $display("starve grant %0d -> %s", k, grants[k] ? "B" : "A");
    end

    // Stalled slave: A requests and x_ack never comes.
    @(posedge wb_clk); #1;
    drive(1'b1, 1'b0, ADR_A, 1'b0, ADR_B, 1'b0, NOISE);
    @(posedge wb_clk); #1;
    drive(1'b0, 1'b1, ADR_A, 1'b0, ADR_B, 1'b0, NOISE);
`ifdef FLASH_ARB_TIMEOUT_EN
    gc = 0;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge wb_clk);
      if (x_if.cyc || a_if.ack) gc++;
      if (a_if.ack) begin
        done = 1;
        chk("wd ack cycle", 32'(gc), 32'(TIMEOUT));
        chk("wd rdt", a_if.rdt, ZERO);
        chk("wd x_cyc", 32'(x_if.cyc), 32'd0);
        @(posedge wb_clk); #1;
        a_if.cyc = 1'b0;
      end
    end
    chk("wd ack seen", 32'(done), 32'd1);
    repeat (5) begin
      @(negedge wb_clk);
      chk("wd t_err sticky", 32'(timeout_err), 32'd1);
    end
    $display("watchdog: ack after %0d grant cycles, timeout_err=%0b", gc, timeout_err);
`else
    gc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge wb_clk);
      if (x_if.cyc) gc++;
    end
    chk("no-wd x_cyc held", 32'(gc), 32'd39);
    chk("no-wd t_err", 32'(timeout_err), 32'd0);
    chk("no-wd a_ack", 32'(a_if.ack), 32'd0);
    $display("no watchdog: x_cyc high for %0d cycles", gc);
`endif
    @(posedge wb_clk); #1;
    drive(1'b1, 1'b0, ADR_A, 1'b0, ADR_B, 1'b0, ZERO);
    @(negedge wb_clk);
    @(negedge wb_clk);
    chk("post-reset t_err", 32'(timeout_err), 32'd0);

    // Random masters and slave against the reference model.
    m_owner = 0; m_rel = 0; m_starve = 0; m_wd = 0; m_terr = 0;
    a_saw_ack = 0;
    b_saw_ack = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge wb_clk);
      model_step();
      #1;
      wb_rst = ($urandom_range(0, 199) == 0);
      if (a_if.cyc && (a_saw_ack || $urandom_range(0, 19) == 0)) begin
        a_if.cyc = 1'b0;
      end else if (!a_if.cyc && $urandom_range(0, 99) < 40) begin
        a_if.cyc = 1'b1;
        a_if.adr = $urandom;
      end
      if (b_if.cyc && (b_saw_ack || $urandom_range(0, 19) == 0)) begin
        b_if.cyc = 1'b0;
      end else if (!b_if.cyc && $urandom_range(0, 99) < 40) begin
        b_if.cyc = 1'b1;
        b_if.adr = $urandom;
      end
      x_if.ack = (m_owner != 0) && ($urandom_range(0, 99) < 30);
      x_if.rdt = $urandom;
      @(negedge wb_clk);
      hit    = m_wd_hit();
      oack   = x_if.ack | hit;
      ordt   = hit ? ZERO : x_if.rdt;
      e_aack = (m_owner == 1) && oack;
      e_back = (m_owner == 2) && oack;
      chk("rnd x_cyc", 32'(x_if.cyc), 32'((m_owner != 0) && m_owner_cyc() && !hit));
      chk("rnd x_adr", x_if.adr,
          (m_owner == 1) ? a_if.adr : (m_owner == 2) ? b_if.adr : ZERO);
      chk("rnd a_ack", 32'(a_if.ack), 32'(e_aack));
      chk("rnd a_rdt", a_if.rdt, (m_owner == 1) ? ordt : ZERO);
      chk("rnd b_ack", 32'(b_if.ack), 32'(e_back));
      chk("rnd b_rdt", b_if.rdt, (m_owner == 2) ? ordt : ZERO);
      chk("rnd busy", 32'(busy), 32'((m_owner != 0) || m_rel));
      chk("rnd grant_b", 32'(grant_b), 32'(m_owner == 2));
      chk("rnd t_err", 32'(timeout_err), 32'(m_terr));
      if (e_aack) $display("txn A adr=%h rdt=%h%s", a_if.adr, ordt, hit ? " (timeout)" : "");
      if (e_back) $display("txn B adr=%h rdt=%h%s", b_if.adr, ordt, hit ? " (timeout)" : "");
      a_saw_ack = e_aack;
      b_saw_ack = e_back;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
